// File: rtl/stream_word_packer.sv
// AXI-Stream upsizer: gathers RATIO narrow lanes into one wide word and flushes
// partial words on TLAST, marking only the written lanes in TKEEP.
module stream_word_packer #(
   parameter int IN_WIDTH  = 8,
   parameter int RATIO     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                      clk,
   input  logic                      aresetn,
   input  logic [IN_WIDTH-1:0]       S_AXIS_TDATA,
   input  logic                      S_AXIS_TVALID,
   input  logic                      S_AXIS_TLAST,
   output logic                      S_AXIS_TREADY,
   output logic [IN_WIDTH*RATIO-1:0] M_AXIS_TDATA,
   output logic [RATIO-1:0]          M_AXIS_TKEEP,
   output logic                      M_AXIS_TLAST,
   output logic                      M_AXIS_TVALID,
   input  logic                      M_AXIS_TREADY
);

   localparam int OUT_WIDTH = IN_WIDTH * RATIO;
   localparam int CNT_W     = $clog2(RATIO);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);
   localparam logic [RATIO-1:0] ONE_KEEP = {{(RATIO-1){1'b0}}, 1'b1};

   localparam logic [0:0] FILL_EMPTY = 1'b0;
   localparam logic [0:0] FILLING    = 1'b1;

   logic [0:0]           state;
   logic [CNT_W-1:0]     cnt;
   logic [OUT_WIDTH-1:0] acc;
   logic [RATIO-1:0]     acck;

   logic [CNT_W-1:0]     pos;
   logic [OUT_WIDTH-1:0] lane_word;
   logic [RATIO-1:0]     lane_keep;
   logic [OUT_WIDTH-1:0] merged_word;
   logic [RATIO-1:0]     merged_keep;
   logic                 accept;
   logic                 complete;

   // Ready is held low in reset so no lane is taken while state is being cleared.
   assign S_AXIS_TREADY = aresetn && !(M_AXIS_TVALID && !M_AXIS_TREADY);
   assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
   assign complete      = accept && ((cnt == LAST_CNT) || S_AXIS_TLAST);

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      pos         = LSB_FIRST ? cnt : (LAST_CNT - cnt);
      lane_word   = OUT_WIDTH'(S_AXIS_TDATA) << (pos * IN_WIDTH);
      lane_keep   = ONE_KEEP << pos;
      merged_word = ((state == FILL_EMPTY) ? '0 : acc) | lane_word;
      merged_keep = ((state == FILL_EMPTY) ? '0 : acck) | lane_keep;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= FILL_EMPTY;
         cnt           <= '0;
         acc           <= '0;
         acck          <= '0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TKEEP  <= '0;
         M_AXIS_TLAST  <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
      end else if (complete) begin
         // Completion only happens when the output slot is free or draining this edge.
         M_AXIS_TDATA  <= merged_word;
         M_AXIS_TKEEP  <= merged_keep;
         M_AXIS_TLAST  <= S_AXIS_TLAST;
         M_AXIS_TVALID <= 1'b1;
         acc           <= '0;
         acck          <= '0;
         cnt           <= '0;
         state         <= FILL_EMPTY;
      end else begin
         if (accept) begin
            acc   <= merged_word;
            acck  <= merged_keep;
            cnt   <= cnt + 1'b1;
            state <= FILLING;
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
         end
      end
   end

endmodule

// File: doc/stream_word_packer.md
Name: stream_word_packer

Overview:
- AXI-Stream upsizer that packs RATIO consecutive IN_WIDTH-bit input words into one OUT_WIDTH = IN_WIDTH*RATIO output word.
- Sits directly upstream of the stream bit-reverse stage. It converts a narrow byte/lane stream into the full-width words that stage consumes.
- Handles packet ends: an S_AXIS_TLAST flushes a partial word with lane-valid TKEEP.

Parameters:
- IN_WIDTH, 8, width of one input word (lane).
- RATIO, 4, input words per output word; legal range 2..16.
- LSB_FIRST, 1, 1: first accepted lane goes to bits [IN_WIDTH-1:0]; 0: first accepted lane goes to the top lane.
- OUT_WIDTH (localparam), IN_WIDTH*RATIO, output data width.

Ports:
- clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous active-low reset.
- S_AXIS_TDATA  in  IN_WIDTH  input lane data.
- S_AXIS_TVALID  in  1  input valid.
- S_AXIS_TLAST  in  1  last lane of packet.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  OUT_WIDTH  packed word.
- M_AXIS_TKEEP  out  RATIO  one bit per lane position; 1 = lane holds valid data.
- M_AXIS_TLAST  out  1  word contains the packet's last lane.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- State:
  - lane counter cnt, 0..RATIO-1.
  - accumulator acc (OUT_WIDTH) and keep mask acck (RATIO).
  - output register (TDATA/TKEEP/TLAST/TVALID).
  - States: FILL_EMPTY (cnt=0, acc cleared) and FILLING (cnt>0).
- Reset (aresetn low, asynchronous):
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TKEEP=0, M_AXIS_TLAST=0.
  - cnt=0, acc=0, acck=0.
  - Reset mid-fill or mid-stall discards all partial and pending data; no output after release until RATIO new lanes or a TLAST are accepted.
- Ready: S_AXIS_TREADY = !(M_AXIS_TVALID && !M_AXIS_TREADY).
  - Combinational from registered valid and downstream ready.
  - While low, the block makes no state change except holding outputs.
  - S_AXIS_TREADY is 0 during reset.
- Lane position p:
  - p = cnt if LSB_FIRST=1, else RATIO-1-cnt.
  - Accepted data is written to bits [p*IN_WIDTH +: IN_WIDTH]; acck[p] is set.
- Input accept (S_AXIS_TVALID && S_AXIS_TREADY):
  - If cnt==RATIO-1 or S_AXIS_TLAST=1 (completion):
    - Load the output register with acc|new lane, acck|new bit, TLAST=S_AXIS_TLAST, TVALID=1.
    - Clear acc/acck; cnt=0.
  - Otherwise: merge the lane into acc and increment cnt.
- Latency: M_AXIS_TVALID is high the cycle after the completing input handshake (one register stage).
- Output:
  - An M handshake (TVALID && TREADY) with no simultaneous completion drops TVALID to 0.
  - An M handshake with a simultaneous completion reloads the register and TVALID stays 1. This gives full throughput: one output every RATIO cycles with no bubbles.
  - TDATA, TKEEP and TLAST are stable while TVALID=1 and TREADY=0.
- Partial flush: lanes not written are 0 in TDATA and 0 in TKEEP.
- TLAST on the first lane of a word emits a single-lane word, TKEEP with one bit set.
- Invariants:
  - Full words have TKEEP all ones.
  - TKEEP is never 0 when TVALID=1.
  - TLAST=0 implies TKEEP all ones.
- No internal drop: every accepted lane appears exactly once at the output, in order.

Test Plan:
- Defaults, bytes 0x11,0x22,0x33,0x44 back-to-back, TLAST on 0x44, M_AXIS_TREADY=1 -> one word 0x44332211, TKEEP=0xF, TLAST=1; TVALID high exactly the cycle after the 0x44 handshake.
- Bytes 0xAA,0xBB with TLAST on 0xBB -> 0x0000BBAA, TKEEP=0x3, TLAST=1. Next bytes 0x01..0x04 -> 0x04030201, TKEEP=0xF.
- LSB_FIRST=0, bytes 0x11,0x22,0x33 TLAST on 0x33 -> 0x11223300, TKEEP=0xE, TLAST=1.
- Continuous 16-byte stream 0x00..0x0F, TREADY=1 -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. S_AXIS_TREADY never drops; one output every 4 cycles.
- Hold M_AXIS_TREADY=0 with a word pending -> S_AXIS_TREADY=0, outputs stable for 10 cycles. Release -> word accepted once, input resumes next cycle, no lane lost or duplicated.
- Accept 0x55,0x66, assert aresetn=0 for 2 cycles, then send 0x01..0x04 -> all outputs 0 during reset. Only 0x04030201 emitted; 0x55/0x66 never appear.
